cam_pixel_packer: RTL
=====================

CAM_PIXEL_PACKER -- requirements
Module: cam_pixel_packer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning pixels per active line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 SHALL have port clock  input  1  single pixel-domain clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cam_vsync  input  1  camera frame sync, active-high, already synchronised to clock.
REQ-006 SHALL have port cam_href  input  1  camera line-valid, active-high.
REQ-007 SHALL have port cam_byte_valid  input  1  qualifies cam_data this cycle.
REQ-008 SHALL have port cam_data  input  8  camera byte; RGB565 high byte first.
REQ-009 SHALL have port fifo_full  input  1  downstream pixel FIFO full.
REQ-010 SHALL have port fifo_write_en  output  1  one-cycle write strobe into the pixel FIFO.
REQ-011 SHALL have port fifo_data_out  output  16  packed RGB565 pixel, valid when fifo_write_en=1.
REQ-012 SHALL have port frame_active  output  1  high while packing the current frame (state S_ACTIVE).
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when line V_ACTIVE completes.
REQ-014 SHALL have port overflow  output  1  sticky flag: a pixel was lost to fifo_full.
REQ-015 SHALL have port frame_count  output  16  frames started (stats feature).
REQ-016 SHALL have port drop_count  output  16  frames dropped due to overflow (stats feature).

Function
REQ-017 SHALL implement states S_WAIT_FRAME, S_ACTIVE, S_DROP; S_WAIT_FRAME after reset.
REQ-018 SHALL detect frame start as cam_vsync 0->1, using a one-cycle registered copy of cam_vsync.
REQ-019 SHALL, on frame start in any state, go to S_ACTIVE and clear byte phase, pixel counter and line counter in the same cycle.
REQ-020 SHALL, in S_ACTIVE with cam_href=1 and cam_byte_valid=1, latch the byte as high byte when phase=0 and toggle phase to 1.
REQ-021 SHALL, with phase=1, form {high_byte, cam_data}, clear phase, and assert fifo_write_en with that data exactly one cycle later (latency 1).
REQ-022 SHALL write a pixel only if pixel counter < H_ACTIVE and line counter < V_ACTIVE; excess pixels and lines are discarded silently.
REQ-023 SHALL, when a pixel completes while fifo_full=1, not write it, set overflow, and go to S_DROP.
REQ-024 SHALL, in S_DROP, ignore all bytes until the next frame start; frame_active=0.
REQ-025 SHALL, on cam_href 1->0, clear phase (discarding an orphan high byte), clear pixel counter, and increment line counter, saturating at V_ACTIVE.
REQ-026 SHALL pulse frame_done for one cycle when line counter becomes V_ACTIVE in S_ACTIVE, then go to S_WAIT_FRAME.
REQ-027 SHALL ignore cam_byte_valid when cam_href=0.
REQ-028 SHALL give frame start priority when it coincides with a byte or href edge.

Reset
REQ-029 SHALL, with resetn=0 at a clock edge, set fifo_write_en=0, fifo_data_out=0, frame_active=0, frame_done=0, overflow=0, frame_count=0, drop_count=0, all counters/phase to 0, and the registered vsync copy to 1, so that high vsync at release is not taken as a frame start.
REQ-030 SHALL, on reset mid-frame, abandon the partial pixel; no write occurs in the cycle after reset asserts.

Configuration
REQ-031 SHALL, when PACKER_STATS_EN is defined, increment frame_count (16-bit, wrapping) on each frame start and increment drop_count (16-bit, saturating at 16'hFFFF) on each S_ACTIVE->S_DROP transition.
REQ-032 SHALL, when PACKER_STATS_EN is undefined, tie frame_count and drop_count to 0 and instantiate no counter registers for them.

Structure
REQ-033 SHALL take the state enum, RGB565 width (16), and default H_ACTIVE/V_ACTIVE constants from shared package cam_pkg.
REQ-034 SHALL place rising/falling-edge detection of cam_vsync and cam_href in one sub-module cam_edge_detect.

Verification
REQ-035 Release reset with cam_vsync=1 held, bytes streamed -> no fifo_write_en until the first vsync 0->1.
REQ-036 Frame start, then line of bytes 12,34,56,78 -> writes 16'h1234 then 16'h5678, each one cycle after its low byte.
REQ-037 href falls after 3 bytes AB,CD,EF -> one write 16'hABCD; EF discarded; next line starts at high byte.
REQ-038 fifo_full=1 during the 5th pixel -> exactly 4 writes, overflow=1, frame_active=0, no writes until next vsync; drop_count=1 with PACKER_STATS_EN.
REQ-039 H_ACTIVE=4, V_ACTIVE=2, lines of 6 pixels -> 4 writes per line, frame_done pulses once after line 2 falls.
REQ-040 vsync 0->1 mid-line after a high byte -> phase cleared, next two bytes form a fresh pixel; frame_count +1.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared camera-path types and defaults: packer FSM states, RGB565 pixel type, sensor geometry.
// Pure definitions; no logic, no latency, no backpressure.
package cam_pkg;

    localparam int RGB565_W         = 16;
    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    typedef enum logic [1:0] {
        S_WAIT_FRAME = 2'd0,
        S_ACTIVE     = 2'd1,
        S_DROP       = 2'd2
    } packer_state_t;

    typedef logic [RGB565_W-1:0] rgb565_t;

    // Sensor sends the high byte first, so it lands in the MSBs.
    function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/cam_edge_detect.sv
// Edge detector for camera sync lines: vsync rising and href falling edges, combinational off a 1-cycle history.
// Zero added latency; no backpressure. vsync history resets high so a held-high vsync is not a frame start.
module cam_edge_detect
    import cam_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic cam_vsync,
    input  logic cam_href,
    output logic vsync_rise,
    output logic href_fall
);

    logic vsync_q;
    logic href_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            vsync_q <= 1'b1;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= cam_vsync;
            href_q  <= cam_href;
        end
    end

    assign vsync_rise = cam_vsync & ~vsync_q;
    assign href_fall  = href_q & ~cam_href;

endmodule

// File: rtl/cam_pixel_packer.sv
// Packs RGB565 byte pairs from the camera into 16-bit FIFO writes, 1 cycle after the low byte; PACKER_STATS_EN adds counters.
// No stall: a pixel completing while fifo_full is lost, overflow sets and the rest of the frame is dropped.
module cam_pixel_packer
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic                cam_byte_valid,
    input  logic [7:0]          cam_data,
    input  logic                fifo_full,
    output logic                fifo_write_en,
    output logic [RGB565_W-1:0] fifo_data_out,
    output logic                frame_active,
    output logic                frame_done,
    output logic                overflow,
    output logic [15:0]         frame_count,
    output logic [15:0]         drop_count
);

    localparam int PW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [PW-1:0] PIX_MAX  = PW'(H_ACTIVE);
    localparam logic [LW-1:0] LINE_MAX = LW'(V_ACTIVE);

    packer_state_t state;
    logic          phase;
    logic [7:0]    high_byte;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;

    logic          vsync_rise;
    logic          href_fall;
    logic          byte_ok;
    logic          pixel_done;
    logic          drop_hit;
    logic [LW-1:0] line_next;

    cam_edge_detect u_edge (
        .clock      (clock),
        .resetn     (resetn),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .vsync_rise (vsync_rise),
        .href_fall  (href_fall)
    );

    assign byte_ok    = cam_href & cam_byte_valid;
    // A low byte that lands inside the active window; frame start always wins.
    assign pixel_done = (state == S_ACTIVE) && !vsync_rise && byte_ok && phase
                        && (pix_cnt < PIX_MAX) && (line_cnt < LINE_MAX);
    assign drop_hit   = pixel_done && fifo_full;
    assign line_next  = (line_cnt < LINE_MAX) ? line_cnt + LW'(1) : line_cnt;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= S_WAIT_FRAME;
            phase         <= 1'b0;
            high_byte     <= '0;
            pix_cnt       <= '0;
            line_cnt      <= '0;
            fifo_write_en <= 1'b0;
            fifo_data_out <= '0;
            frame_active  <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            fifo_write_en <= 1'b0;
            frame_done    <= 1'b0;
            if (vsync_rise) begin
                state        <= S_ACTIVE;
                frame_active <= 1'b1;
                phase        <= 1'b0;
                pix_cnt      <= '0;
                line_cnt     <= '0;
            end else if (state == S_ACTIVE) begin
                if (href_fall) begin
                    // End of line: any orphan high byte is thrown away.
                    phase    <= 1'b0;
                    pix_cnt  <= '0;
                    line_cnt <= line_next;
                    if (line_next == LINE_MAX) begin
                        frame_done   <= 1'b1;
                        state        <= S_WAIT_FRAME;
                        frame_active <= 1'b0;
                    end
                end else if (byte_ok) begin
                    if (!phase) begin
                        high_byte <= cam_data;
                        phase     <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (drop_hit) begin
                            overflow     <= 1'b1;
                            state        <= S_DROP;
                            frame_active <= 1'b0;
                        end else if (pixel_done) begin
                            fifo_write_en <= 1'b1;
                            fifo_data_out <= pack_rgb565(high_byte, cam_data);
                            pix_cnt       <= pix_cnt + PW'(1);
                        end
                    end
                end
            end
        end
    end

`ifdef PACKER_STATS_EN
    always_ff @(posedge clock) begin
        if (!resetn) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (vsync_rise) begin
                frame_count <= frame_count + 16'd1;
            end
            if (drop_hit && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

endmodule
